// File: rtl/mdu_pkg.sv
// ---------------------------------------------------------------------------
// mdu_pkg: shared definitions for the multiply/divide unit controllers.
//
// Contents:
//   MDU_OP_WIDTH / MDU_RD_WIDTH  default operand and destination-tag widths
//   FUNC_DIV .. FUNC_REMU        2-bit divide function encodings
//   div_state_e                  div_ctrl sequencing states
// ---------------------------------------------------------------------------
package mdu_pkg;

    localparam int MDU_OP_WIDTH = 32;
    localparam int MDU_RD_WIDTH = 5;

    localparam logic [1:0] FUNC_DIV  = 2'b00;
    localparam logic [1:0] FUNC_DIVU = 2'b01;
    localparam logic [1:0] FUNC_REM  = 2'b10;
    localparam logic [1:0] FUNC_REMU = 2'b11;

    typedef enum logic [2:0] {
        DIV_IDLE  = 3'd0,
        DIV_ISSUE = 3'd1,
        DIV_WAIT  = 3'd2,
        DIV_RESP  = 3'd3,
        DIV_DRAIN = 3'd4
    } div_state_e;

endpackage

// File: rtl/div_zero_fix.sv
// ---------------------------------------------------------------------------
// div_zero_fix: combinational divide-by-zero result generator.
//
// Produces the architectural result of a divide whose divisor is zero:
// DIV/DIVU give all-ones, REM/REMU give the dividend unchanged.
//
// Ports:
//   func_i    in   2         divide function (mdu_pkg FUNC_*)
//   op_a_i    in   OP_WIDTH  dividend
//   result_o  out  OP_WIDTH  divide-by-zero result
// ---------------------------------------------------------------------------
module div_zero_fix
    import mdu_pkg::*;
#(
    parameter int OP_WIDTH = MDU_OP_WIDTH
) (
    input  logic [1:0]          func_i,
    input  logic [OP_WIDTH-1:0] op_a_i,
    output logic [OP_WIDTH-1:0] result_o
);

    always_comb begin
        result_o = op_a_i;
        if ((func_i == FUNC_DIV) || (func_i == FUNC_DIVU)) begin
            result_o = '1;
        end
    end

endmodule

// File: rtl/div_ctrl.sv
// ---------------------------------------------------------------------------
// div_ctrl: sequencing controller between the EX stage and the 3-cycle divider.
//
// Accepts one divide-class request from EX, stalls the pipeline while it is
// in progress, launches the divider with a one-cycle start pulse, holds the
// operands stable until the divider reports done, and returns a one-cycle
// writeback pulse with the destination tag. Flushes are absorbed in every
// state; a flush after the divider has started drains its result.
//
// Handshake: a request is taken in the cycle where ex_valid_i is high, the
// controller is IDLE and flush_i is low. stall_o acts as the inverse of
// ready towards EX: while it is high EX must hold the instruction; it drops
// in the writeback cycle so EX advances together with the result.
//
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   ex_valid_i, ex_func_i         request valid and divide function
//   ex_op_a_i, ex_op_b_i, ex_rd_i dividend, divisor, destination tag
//   flush_i                       kill the current instruction
//   stall_o, busy_o               pipeline hold, controller not idle
//   wb_valid_o, wb_result_o, wb_rd_o   writeback pulse, result, tag
//   div_start_o, div_op_a_o, div_op_b_o, div_func_o   divider launch
//   div_result_i, div_done_i      divider response
//
// Build option: define DIV_ZERO_BYPASS_EN to answer divide-by-zero requests
// directly (one-cycle latency) without starting the divider.
// ---------------------------------------------------------------------------
module div_ctrl
    import mdu_pkg::*;
#(
    parameter int OP_WIDTH = MDU_OP_WIDTH,
    parameter int RD_WIDTH = MDU_RD_WIDTH
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                ex_valid_i,
    input  logic [1:0]          ex_func_i,
    input  logic [OP_WIDTH-1:0] ex_op_a_i,
    input  logic [OP_WIDTH-1:0] ex_op_b_i,
    input  logic [RD_WIDTH-1:0] ex_rd_i,
    input  logic                flush_i,
    output logic                stall_o,
    output logic                busy_o,
    output logic                wb_valid_o,
    output logic [OP_WIDTH-1:0] wb_result_o,
    output logic [RD_WIDTH-1:0] wb_rd_o,
    output logic                div_start_o,
    output logic [OP_WIDTH-1:0] div_op_a_o,
    output logic [OP_WIDTH-1:0] div_op_b_o,
    output logic [1:0]          div_func_o,
    input  logic [OP_WIDTH-1:0] div_result_i,
    input  logic                div_done_i
);

    div_state_e          state_q;
    logic [OP_WIDTH-1:0] op_a_q;
    logic [OP_WIDTH-1:0] op_b_q;
    logic [1:0]          func_q;
    logic [RD_WIDTH-1:0] rd_q;
    logic [OP_WIDTH-1:0] res_q;
    logic                accept;

    // Flush wins over a new request, so nothing is captured in a flush cycle.
    assign accept = (state_q == DIV_IDLE) && ex_valid_i && !flush_i;

`ifdef DIV_ZERO_BYPASS_EN
    logic [OP_WIDTH-1:0] zero_result;
    logic                zero_divisor;

    assign zero_divisor = (ex_op_b_i == '0);

    div_zero_fix #(
        .OP_WIDTH (OP_WIDTH)
    ) u_div_zero_fix (
        .func_i   (ex_func_i),
        .op_a_i   (ex_op_a_i),
        .result_o (zero_result)
    );
`endif

    // Operand registers are written only on acceptance: the divider samples
    // operand_b and func after the start pulse, so they must stay frozen
    // until the controller is back in IDLE.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= DIV_IDLE;
            op_a_q  <= '0;
            op_b_q  <= '0;
            func_q  <= '0;
            rd_q    <= '0;
            res_q   <= '0;
        end else begin
            case (state_q)
                DIV_IDLE: begin
                    if (accept) begin
                        op_a_q <= ex_op_a_i;
                        op_b_q <= ex_op_b_i;
                        func_q <= ex_func_i;
                        rd_q   <= ex_rd_i;
`ifdef DIV_ZERO_BYPASS_EN
                        if (zero_divisor) begin
                            res_q   <= zero_result;
                            state_q <= DIV_RESP;
                        end else begin
                            state_q <= DIV_ISSUE;
                        end
`else
                        state_q <= DIV_ISSUE;
`endif
                    end
                end
                DIV_ISSUE: begin
                    // A flush here means the divider was never started.
                    state_q <= flush_i ? DIV_IDLE : DIV_WAIT;
                end
                DIV_WAIT: begin
                    if (div_done_i) begin
                        if (flush_i) begin
                            state_q <= DIV_IDLE;
                        end else begin
                            res_q   <= div_result_i;
                            state_q <= DIV_RESP;
                        end
                    end else if (flush_i) begin
                        state_q <= DIV_DRAIN;
                    end
                end
                DIV_RESP: begin
                    state_q <= DIV_IDLE;
                end
                DIV_DRAIN: begin
                    // The divider cannot abort; swallow its result.
                    if (div_done_i) begin
                        state_q <= DIV_IDLE;
                    end
                end
                default: begin
                    state_q <= DIV_IDLE;
                end
            endcase
        end
    end

    assign busy_o      = (state_q != DIV_IDLE);
    assign stall_o     = ex_valid_i && (state_q != DIV_RESP) && !flush_i;
    assign div_start_o = (state_q == DIV_ISSUE) && !flush_i;
    assign wb_valid_o  = (state_q == DIV_RESP) && !flush_i;
    assign wb_result_o = res_q;
    assign wb_rd_o     = rd_q;
    assign div_op_a_o  = op_a_q;
    assign div_op_b_o  = op_b_q;
    assign div_func_o  = func_q;

endmodule

// File: tb/tb_div_ctrl.sv
// ---------------------------------------------------------------------------
// tb_div_ctrl: self-checking bench for div_ctrl.
//
// A behavioural 3-cycle divider sits beside the DUT. Each request's outcome
// (written back or killed, result, tag, writeback cycle) is derived from the
// request timeline and pushed into exp_q; a monitor pops and compares on
// every wb_valid_o. The driver also checks stall_o/busy_o/div_start_o cycle
// by cycle against the timeline. Honours DIV_ZERO_BYPASS_EN.
// ---------------------------------------------------------------------------
module tb_div_ctrl;

    localparam int OPW = 32;
    localparam int RDW = 5;
    localparam int EW  = 32 + RDW + OPW;   // {cycle, rd, result}

`ifdef DIV_ZERO_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic clk_i = 1'b0;
    logic rst_ni;
    always #5 clk_i = ~clk_i;

    int cyc = 0;
    initial forever begin
        @(posedge clk_i);
        cyc++;
    end

    // ------------------------------------------------------------------
    // DUT
    // ------------------------------------------------------------------
    logic            ex_valid_i;
    logic [1:0]      ex_func_i;
    logic [OPW-1:0]  ex_op_a_i;
    logic [OPW-1:0]  ex_op_b_i;
    logic [RDW-1:0]  ex_rd_i;
    logic            flush_i;
    logic            stall_o;
    logic            busy_o;
    logic            wb_valid_o;
    logic [OPW-1:0]  wb_result_o;
    logic [RDW-1:0]  wb_rd_o;
    logic            div_start_o;
    logic [OPW-1:0]  div_op_a_o;
    logic [OPW-1:0]  div_op_b_o;
    logic [1:0]      div_func_o;
    logic [OPW-1:0]  div_result_i;
    logic            div_done_i;

    div_ctrl #(.OP_WIDTH(OPW), .RD_WIDTH(RDW)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .ex_valid_i   (ex_valid_i),
        .ex_func_i    (ex_func_i),
        .ex_op_a_i    (ex_op_a_i),
        .ex_op_b_i    (ex_op_b_i),
        .ex_rd_i      (ex_rd_i),
        .flush_i      (flush_i),
        .stall_o      (stall_o),
        .busy_o       (busy_o),
        .wb_valid_o   (wb_valid_o),
        .wb_result_o  (wb_result_o),
        .wb_rd_o      (wb_rd_o),
        .div_start_o  (div_start_o),
        .div_op_a_o   (div_op_a_o),
        .div_op_b_o   (div_op_b_o),
        .div_func_o   (div_func_o),
        .div_result_i (div_result_i),
        .div_done_i   (div_done_i)
    );

    // ------------------------------------------------------------------
    // Reference arithmetic
    // ------------------------------------------------------------------
    function automatic logic [31:0] riscv_div(input logic [1:0] f, input logic [31:0] a,
                                              input logic [31:0] b);
        int  sa;
        int  sb;
        bit  ovf;
        sa  = a;
        sb  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        if (b == 32'd0) return f[1] ? a : 32'hFFFF_FFFF;
        case (f)
            2'b00:   return ovf ? a : 32'(sa / sb);
            2'b01:   return a / b;
            2'b10:   return ovf ? 32'd0 : 32'(sa % sb);
            default: return a % b;
        endcase
    endfunction

    // The divider works on magnitudes and fixes the sign afterwards, so a
    // signed divide-by-zero of a negative dividend comes out as +1.
    function automatic logic [31:0] divider_hw(input logic [1:0] f, input logic [31:0] a,
                                               input logic [31:0] b);
        if ((b == 32'd0) && (f == 2'b00) && a[31]) return 32'd1;
        return riscv_div(f, a, b);
    endfunction

    function automatic logic [31:0] expected_result(input logic [1:0] f, input logic [31:0] a,
                                                    input logic [31:0] b);
        return BYPASS ? riscv_div(f, a, b) : divider_hw(f, a, b);
    endfunction

    // ------------------------------------------------------------------
    // Behavioural divider: done two cycles after the start cycle
    // ------------------------------------------------------------------
    initial begin
        bit start_seen;
        int cnt;
        div_done_i   = 1'b0;
        div_result_i = '0;
        cnt          = 0;
        forever begin
            @(negedge clk_i);
            start_seen = (div_start_o === 1'b1) && (rst_ni === 1'b1);
            @(posedge clk_i);
            #1;
            div_done_i = 1'b0;
            if (rst_ni !== 1'b1) begin
                cnt = 0;
            end else begin
                if (start_seen) cnt = 2;
                if (cnt != 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        div_done_i   = 1'b1;
                        div_result_i = divider_hw(div_func_o, div_op_a_o, div_op_b_o);
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    logic [EW-1:0] exp_q[$];
    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every writeback must match the oldest outstanding expectation.
    initial begin
        logic [EW-1:0] e;
        forever begin
            @(negedge clk_i);
            if (wb_valid_o === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL wb_unexpected: got result %h rd %0d expected no writeback (cycle %0d)",
                             wb_result_o, wb_rd_o, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("wb_result", wb_result_o, e[OPW-1:0]);
                    check("wb_rd", 32'(wb_rd_o), 32'(e[OPW+RDW-1:OPW]));
                    check("wb_cycle", 32'(cyc), e[EW-1:OPW+RDW]);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Driver tasks (all start and end at posedge + 1)
    // ------------------------------------------------------------------
    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic scramble_ex();
        ex_func_i = 2'($urandom);
        ex_op_a_i = $urandom;
        ex_op_b_i = $urandom;
        ex_rd_i   = RDW'($urandom);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_bit({tag, "_stall"}, stall_o, 1'b0);
        check_bit({tag, "_busy"}, busy_o, 1'b0);
        check_bit({tag, "_wb_valid"}, wb_valid_o, 1'b0);
        check_bit({tag, "_start"}, div_start_o, 1'b0);
        check({tag, "_wb_result"}, wb_result_o, 32'd0);
        check({tag, "_wb_rd"}, 32'(wb_rd_o), 32'd0);
        check({tag, "_op_a"}, div_op_a_o, 32'd0);
        check({tag, "_op_b"}, div_op_b_o, 32'd0);
        check({tag, "_func"}, 32'(div_func_o), 32'd0);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            ex_valid_i = 1'b0;
            flush_i    = 1'b0;
            scramble_ex();
            @(negedge clk_i);
            check_bit("idle_busy", busy_o, 1'b0);
            check_bit("idle_stall", stall_o, 1'b0);
            next_cycle();
        end
    endtask

    // One request from EX. kill = cycle (relative to acceptance) in which
    // flush_i is pulsed, 0 for none. EX holds the instruction until it is
    // written back or flushed; after cycle 0 the operand buses carry junk
    // so that any late re-capture shows up in the result.
    task automatic run_txn(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                           input logic [RDW-1:0] rd, input int kill);
        bit byp;
        bit killed;
        int resp;
        int idle;
        int end_v;
        int base;
        byp    = BYPASS && (b == 32'd0);
        resp   = byp ? 1 : 4;
        killed = (kill >= 1) && (kill <= resp);
        end_v  = killed ? kill : resp;
        if (!killed)          idle = resp + 1;
        else if (kill == 1)   idle = 2;
        else if (kill == 4)   idle = 5;
        else                  idle = 4;     // drained, or flushed with done
        base = cyc;
        if (!killed) exp_q.push_back({32'(base + resp), rd, expected_result(f, a, b)});
        for (int c = 0; c < idle; c++) begin
            ex_valid_i = (c <= end_v);
            flush_i    = killed && (c == kill);
            if (c == 0) begin
                ex_func_i = f;
                ex_op_a_i = a;
                ex_op_b_i = b;
                ex_rd_i   = rd;
            end else begin
                scramble_ex();
            end
            @(negedge clk_i);
            check_bit("stall", stall_o, c < end_v);
            check_bit("busy", busy_o, c >= 1);
            check_bit("div_start", div_start_o, !byp && (c == 1) && !(killed && kill == 1));
            next_cycle();
        end
        ex_valid_i = 1'b0;
        flush_i    = 1'b0;
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    endtask

    // Flush in IDLE has priority: the request must not be taken.
    task automatic flush_in_idle();
        ex_valid_i = 1'b1;
        flush_i    = 1'b1;
        scramble_ex();
        @(negedge clk_i);
        check_bit("idle_flush_stall", stall_o, 1'b0);
        check_bit("idle_flush_start", div_start_o, 1'b0);
        next_cycle();
        ex_valid_i = 1'b0;
        flush_i    = 1'b0;
        @(negedge clk_i);
        check_bit("idle_flush_busy", busy_o, 1'b0);
        next_cycle();
    endtask

    // Reset asserted in cycle 2 of a DIVU: outputs return to reset values at
    // once and the aborted request never writes back.
    task automatic reset_mid();
        for (int c = 0; c < 2; c++) begin
            ex_valid_i = 1'b1;
            flush_i    = 1'b0;
            ex_func_i  = 2'b01;
            ex_op_a_i  = 32'd1000;
            ex_op_b_i  = 32'd3;
            ex_rd_i    = 5'd9;
            next_cycle();
        end
        ex_valid_i = 1'b0;
        rst_ni     = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        next_cycle();
        next_cycle();
        rst_ni = 1'b1;
        idle_cycles(6);
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        rst_ni     = 1'b0;
        ex_valid_i = 1'b0;
        flush_i    = 1'b0;
        ex_func_i  = '0;
        ex_op_a_i  = '0;
        ex_op_b_i  = '0;
        ex_rd_i    = '0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check_reset_outputs("rst");
        next_cycle();
        rst_ni = 1'b1;
        next_cycle();

        // Directed cases
        run_txn(2'b01, 32'd15, 32'd7, 5'd3, 0);            // DIVU -> 2
        run_txn(2'b11, 32'd15, 32'd7, 5'd4, 0);            // REMU -> 1
        run_txn(2'b00, 32'd100, 32'd7, 5'd5, 0);           // back-to-back DIV -> 14
        run_txn(2'b00, 32'd15, 32'd7, 5'd6, 2);            // flush in WAIT -> drain
        run_txn(2'b00, 32'd15, 32'd7, 5'd6, 0);            // next one normal
        run_txn(2'b01, 32'd15, 32'd7, 5'd7, 1);            // flush in ISSUE
        run_txn(2'b10, 32'hFFFF_FF00, 32'd7, 5'd8, 3);     // flush together with done
        run_txn(2'b00, 32'hFFFF_FF00, 32'd7, 5'd8, 4);     // flush in RESP
        run_txn(2'b00, 32'hFFFF_FFF9, 32'd0, 5'd10, 0);    // DIV by zero
        run_txn(2'b10, 32'hFFFF_FFF9, 32'd0, 5'd11, 0);    // REM by zero
        run_txn(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 0);  // signed overflow
        flush_in_idle();
        idle_cycles(1);

        // Randomized traffic
        for (int n = 0; n < 80; n++) begin
            logic [1:0]     f;
            logic [31:0]    a;
            logic [31:0]    b;
            logic [RDW-1:0] rd;
            int             kill;
            f  = 2'($urandom_range(0, 3));
            a  = ($urandom_range(0, 9) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = 32'($urandom_range(1, 16));
                default: b = $urandom;
            endcase
            rd   = RDW'($urandom);
            kill = ($urandom_range(0, 9) < 6) ? 0 : $urandom_range(1, 5);
            run_txn(f, a, b, rd, kill);
            if ($urandom_range(0, 9) == 0) flush_in_idle();
            idle_cycles($urandom_range(0, 2));
        end

        reset_mid();
        run_txn(2'b01, 32'd15, 32'd7, 5'd3, 0);            // recovers after reset

        check("final_exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/div_ctrl.md
# div_ctrl

Sequencing controller between the EX stage of the 5-stage RISC-V pipeline and the 3-cycle `divider`. It accepts a DIV/DIVU/REM/REMU request from EX and stalls the pipeline while the request is in progress. It launches the divider with a one-cycle start pulse, holds its operands stable until `div_done_i`, and returns a one-cycle writeback pulse carrying the destination tag. It also absorbs flushes, including flushes that arrive while the divider is in flight.

## Interface
- OP_WIDTH, 32, operand/result width.
- RD_WIDTH, 5, destination register tag width.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- ex_valid_i  in  1  EX holds a divide-class instruction.
- ex_func_i  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
- ex_op_a_i  in  OP_WIDTH  dividend.
- ex_op_b_i  in  OP_WIDTH  divisor.
- ex_rd_i  in  RD_WIDTH  destination tag.
- flush_i  in  1  kill current instruction.
- stall_o  out  1  hold IF/ID/EX.
- busy_o  out  1  state ≠ IDLE.
- wb_valid_o  out  1  result valid, one-cycle pulse.
- wb_result_o  out  OP_WIDTH  result.
- wb_rd_o  out  RD_WIDTH  tag of the result.
- div_start_o  out  1  start pulse to divider.
- div_op_a_o, div_op_b_o  out  OP_WIDTH  registered operands to divider.
- div_func_o  out  2  registered func to divider.
- div_result_i  in  OP_WIDTH  divider result.
- div_done_i  in  1  divider result valid.

## Operation
- Registers:
  - op_a, op_b, func, rd: captured in IDLE on acceptance; held constant until the FSM returns to IDLE. The divider samples `operand_b_i` and `func_i` after start, so these must not change mid-operation.
  - res: the result register.
- FSM states: IDLE, ISSUE, WAIT, RESP, DRAIN.
- IDLE:
  - ex_valid_i & !flush_i → capture operands and tag, go to ISSUE.
  - flush_i has priority over ex_valid_i; nothing is captured.
- ISSUE:
  - div_start_o = !flush_i.
  - flush_i → IDLE, divider not started.
  - Otherwise → WAIT.
- WAIT:
  - div_done_i → res ← div_result_i, go to RESP.
  - flush_i & !div_done_i → DRAIN.
  - flush_i & div_done_i → IDLE, result discarded.
- RESP:
  - wb_valid_o = !flush_i; go to IDLE unconditionally.
  - A new request is not accepted in RESP. The next request is accepted in the following IDLE cycle.
- DRAIN: the divider cannot abort, so wait for div_done_i, discard the result, go to IDLE.
- stall_o = ex_valid_i & !(state == RESP) & !flush_i. stall_o is combinational; it is low in RESP so EX advances in that same cycle.
- wb_result_o = res; wb_rd_o = rd. Both are stable throughout RESP.
- Widths: all datapaths are OP_WIDTH. Results are not sign-extended or truncated.

## Timing
- Reset values:
  - state = IDLE.
  - stall_o, busy_o, wb_valid_o, div_start_o = 0.
  - wb_result_o, div_op_a_o, div_op_b_o = 0; wb_rd_o = 0; div_func_o = 00.
- Normal latency, with request accepted in cycle 0:
  - ISSUE (div_start_o) in cycle 1.
  - Divider EXECUTE in cycle 2; div_done_i in cycle 3.
  - RESP (wb_valid_o) in cycle 4.
  - stall_o is high in cycles 0–3.
- Back-to-back requests: the second request is accepted in cycle 5. Throughput is one divide per 5 cycles.
- Reset mid-operation: immediate return to IDLE with all outputs at reset values. The divider shares rst_ni, so no drain is needed.
- A div_done_i arriving in IDLE, ISSUE or RESP is ignored.

## Configuration
- Macro: `DIV_ZERO_BYPASS_EN`.
- Defined:
  - In IDLE, an accepted request with op_b == 0 goes directly to RESP; the divider is not started.
  - Result follows RISC-V rules: DIV/DIVU → all-ones; REM/REMU → op_a unmodified.
  - Latency is 1 cycle, with RESP in cycle 1.
- Undefined:
  - Divide-by-zero is routed through the divider like any other request, and its result is forwarded unmodified.
  - The DIV result is then all-ones only for non-negative dividends.

## Structure
- Shared package `mdu_pkg`:
  - func encodings: FUNC_DIV, FUNC_DIVU, FUNC_REM, FUNC_REMU.
  - div_ctrl state enum.
  - OP_WIDTH default.
- One sub-module, `div_zero_fix`: a combinational generator of the divide-by-zero result from func and op_a. It is instantiated only under `DIV_ZERO_BYPASS_EN`.
- The divider is instantiated beside div_ctrl in the EX-stage wrapper, not inside div_ctrl.

## Test plan
- DIVU a=15, b=7, rd=3 → div_start_o in cycle 1; wb_valid_o in cycle 4 with result 2, rd 3; stall_o high cycles 0–3.
- REMU a=15, b=7 → result 1 in cycle 4. Then DIV a=100, b=7 held on ex_valid_i → second request accepted in cycle 5, result 14 in cycle 9.
- DIV a=15, b=7 with flush_i pulsed in cycle 2 → DRAIN; no wb_valid_o; busy_o low by cycle 4; next request accepted normally.
- Flush in ISSUE (cycle 1) → div_start_o stays 0; IDLE in cycle 2.
- With `DIV_ZERO_BYPASS_EN`:
  - DIV a=0xFFFFFFF9, b=0 → result 0xFFFFFFFF in cycle 1; div_start_o never asserted.
  - REM a=0xFFFFFFF9, b=0 → result 0xFFFFFFF9.
- rst_ni low in cycle 2 of a DIVU → all outputs at reset values immediately; no wb_valid_o after release.
